beam_scan_ctrl: RTL and testbench

Steering scheduler for the PDM mic-array beamformer. It sequences the shared delay-and-sum datapath through N_ANGLES steering angles. For each angle it discards a settle interval, then accumulates beam magnitude over a fixed window of PCM strobes. It reports the strongest angle and its energy once per scan. It sits between the audio clock's PCM strobe, the beamformer's angle-select input and downstream direction-of-arrival logic.

---
 rtl/beam_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_beam_scan_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_ctrl.sv
// rtl/beam_scan_ctrl.sv - steering scheduler sweeping beamformer angles and reporting the strongest one
module beam_scan_ctrl #(
    parameter int N_ANGLES = 5,
    parameter int WINDOW   = 32,
    parameter int SETTLE   = 8,
    parameter int DW       = 16,
    parameter int ACCW     = 40,
    parameter int AW       = $clog2(N_ANGLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_pcm,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    input  logic signed [DW-1:0] beam_in,
    output logic [AW-1:0]        angle_sel,
    output logic                 busy,
    output logic [AW-1:0]        result_angle,
    output logic [ACCW-1:0]      result_energy,
    output logic                 result_valid
);

    localparam int CNT_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW - 1);
    localparam logic [AW-1:0] LAST_ANGLE  = AW'(N_ANGLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   angle_q;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] best_q;
    logic [AW-1:0]   best_angle_q;
    logic [AW-1:0]   result_angle_q;
    logic [ACCW-1:0] result_energy_q;
    logic            result_valid_q;

    // Magnitude as unsigned DW bits, so the most negative sample maps exactly to 2^(DW-1).
    logic [DW-1:0]   beam_u;
    logic [DW-1:0]   mag_d;
    logic [ACCW-1:0] acc_d;
    logic            better_d;
    logic [ACCW-1:0] best_d;
    logic [AW-1:0]   best_angle_d;

    assign beam_u       = beam_in;
    assign mag_d        = beam_u[DW-1] ? (~beam_u + DW'(1)) : beam_u;
    assign acc_d        = acc_q + ACCW'(mag_d);
    assign better_d     = (angle_q == '0) || (acc_q > best_q);
    assign best_d       = better_d ? acc_q : best_q;
    assign best_angle_d = better_d ? angle_q : best_angle_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            angle_q         <= '0;
            acc_q           <= '0;
            best_q          <= '0;
            best_angle_q    <= '0;
            result_angle_q  <= '0;
            result_energy_q <= '0;
            result_valid_q  <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                angle_q <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_SETTLE;
                            cnt_q   <= '0;
                            angle_q <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (en_pcm) begin
                            if (cnt_q == SETTLE_LAST) begin
                                state_q <= S_ACCUM;
                                cnt_q   <= '0;
                                acc_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (en_pcm) begin
                            acc_q <= acc_d;
                            if (cnt_q == WINDOW_LAST) begin
                                state_q <= S_COMPARE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    S_COMPARE: begin
                        best_q       <= best_d;
                        best_angle_q <= best_angle_d;
                        // Results take the winner including this angle on the same edge.
                        if (angle_q == LAST_ANGLE) begin
                            state_q         <= S_DONE;
                            result_angle_q  <= best_angle_d;
                            result_energy_q <= best_d;
                            result_valid_q  <= 1'b1;
                        end else begin
                            state_q <= S_SETTLE;
                            angle_q <= angle_q + AW'(1);
                            cnt_q   <= '0;
                        end
                    end
                    S_DONE: begin
                        angle_q <= '0;
                        cnt_q   <= '0;
                        state_q <= continuous ? S_SETTLE : S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign angle_sel     = angle_q;
    assign busy          = (state_q != S_IDLE);
    assign result_angle  = result_angle_q;
    assign result_energy = result_energy_q;
    assign result_valid  = result_valid_q;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// tb/tb_beam_scan_ctrl.sv - self-checking bench for beam_scan_ctrl against a per-angle energy model
module tb_beam_scan_ctrl;
    localparam int N    = 5;
    localparam int W    = 4;
    localparam int S    = 2;
    localparam int DW   = 16;
    localparam int ACCW = 40;
    localparam int AW   = $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en_pcm;
    logic                 start;
    logic                 continuous;
    logic                 abort;
    logic signed [DW-1:0] beam_in;
    logic [AW-1:0]        angle_sel;
    logic                 busy;
    logic [AW-1:0]        result_angle;
    logic [ACCW-1:0]      result_energy;
    logic                 result_valid;

    beam_scan_ctrl #(
        .N_ANGLES(N), .WINDOW(W), .SETTLE(S), .DW(DW), .ACCW(ACCW), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .en_pcm(en_pcm), .start(start),
        .continuous(continuous), .abort(abort), .beam_in(beam_in),
        .angle_sel(angle_sel), .busy(busy), .result_angle(result_angle),
        .result_energy(result_energy), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Stimulus source: held per-angle table (mode 0) or fresh random sample each clk (mode 1)
    int period = 4;
    int phase  = 0;
    int mode   = 0;
    int tbl [N];
    int cyc    = 0;

    function automatic logic signed [DW-1:0] rnd_beam();
        case ($urandom_range(0, 7))
            0:       return 16'sh8000;
            1:       return 16'sh7fff;
            2:       return '0;
            default: return DW'($urandom);
        endcase
    endfunction

    logic rst_e   = 1'b1;
    logic abort_e = 1'b0;
    always @(posedge clk) begin
        rst_e   <= reset;
        abort_e <= abort;
    end

    // Model: energy of an angle = sum of |beam| over the strobes numbered
    // SETTLE+1..SETTLE+WINDOW after that angle becomes selected.
    longint energy [N];
    int     nsamp     = 0;
    bit     prev_busy = 1'b0;
    int     prev_sel  = 0;
    int     pend      = -1;
    int     pend_a    = 0;
    longint pend_e    = 0;
    int     res_a     = 0;
    longint res_e     = 0;
    int     post      = -1;
    bit     cont_at   = 1'b0;

    always @(negedge clk) begin
        longint b;
        bit     exp_v;
        phase  = (phase + 1 >= period) ? 0 : phase + 1;
        en_pcm = (phase == 0);
        if (mode == 0) beam_in = (int'(angle_sel) < N) ? DW'(tbl[angle_sel]) : '0;
        else           beam_in = rnd_beam();
        cyc++;

        if (!rst_e) begin
            pend  = -1;
            post  = -1;
            res_a = 0;
            res_e = 0;
            chk("reset_busy", busy, 0);
            chk("reset_angle_sel", angle_sel, 0);
        end else if (abort_e && prev_busy) begin
            pend = -1;
            chk("abort_busy", busy, 0);
        end

        if (busy) begin
            if (!prev_busy || int'(angle_sel) != prev_sel) begin
                if (prev_busy) begin
                    chk("angle_step", angle_sel, (prev_sel + 1) % N);
                    chk("angle_strobe_count", (nsamp == S + W || nsamp == S + W + 1), 1);
                end else begin
                    chk("scan_first_angle", angle_sel, 0);
                end
                if (angle_sel == 0) for (int a = 0; a < N; a++) energy[a] = 0;
                nsamp = 0;
            end
            if (en_pcm) begin
                nsamp++;
                b = beam_in;
                if (b < 0) b = -b;
                if (nsamp > S && nsamp <= S + W) energy[angle_sel] += b;
                if (nsamp == S + W && int'(angle_sel) == N - 1) begin
                    pend_a = 0;
                    pend_e = energy[0];
                    for (int a = 1; a < N; a++)
                        if (energy[a] > pend_e) begin
                            pend_a = a;
                            pend_e = energy[a];
                        end
                    pend = cyc + 2;
                end
            end
        end

        exp_v = (cyc == pend);
        if (exp_v) begin
            res_a   = pend_a;
            res_e   = pend_e;
            cont_at = continuous;
            post    = cyc + 1;
        end
        chk("result_valid", result_valid, exp_v);
        chk("result_angle", result_angle, res_a);
        chk("result_energy", result_energy, res_e);
        if (cyc == post && rst_e) begin
            chk("post_pulse_busy", busy, cont_at);
            if (cont_at) chk("post_pulse_angle_sel", angle_sel, 0);
        end
        prev_busy = busy;
        prev_sel  = angle_sel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_angle_sel", angle_sel, 0);
    endtask

    task automatic wait_valid(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (result_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("result_valid_timeout", 0, 1);
    endtask

    task automatic wait_strobes(input int k);
        int seen = 0;
        for (int i = 0; i < 400 && seen < k; i++) begin
            tick();
            if (en_pcm) seen++;
        end
        if (seen < k) chk("strobe_wait_timeout", seen, k);
    endtask

    task automatic wait_sel(input int a);
        bit got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (int'(angle_sel) == a) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("angle_sel_timeout", 0, 1);
    endtask

    task automatic run_scan(input string name, input int ea, input longint ee);
        do_start();
        wait_valid(600);
        chk({name, "_angle"}, result_angle, ea);
        chk({name, "_energy"}, result_energy, ee);
        tick();
        chk({name, "_valid_one_clk"}, result_valid, 0);
        chk({name, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        abort      = 1'b0;
        en_pcm     = 1'b0;
        beam_in    = '0;
        tbl        = '{10, 50, -300, 20, 5};
        repeat (3) tick();
        chk("reset_result_energy", result_energy, 0);
        chk("reset_result_valid", result_valid, 0);
        reset = 1'b1;
        tick();

        run_scan("s1", 2, 1200);
        tbl = '{100, 100, 100, 100, 100};
        run_scan("s2_tie", 0, 400);
        tbl = '{1000, 1000, 1000, 1000, -32768};
        run_scan("s3_minneg", 4, 131072);

        tbl        = '{10, 50, -300, 20, 5};
        continuous = 1'b1;
        do_start();
        wait_strobes(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(600);
        chk("s4_first_angle", result_angle, 2);
        chk("s4_first_energy", result_energy, 1200);
        tbl = '{0, 500, 0, 0, 0};
        tick();
        chk("s4_cont_busy", busy, 1);
        chk("s4_cont_angle_sel", angle_sel, 0);
        continuous = 1'b0;
        wait_valid(600);
        chk("s4_second_angle", result_angle, 1);
        chk("s4_second_energy", result_energy, 2000);
        tick();
        chk("s4_busy_fall", busy, 0);

        tbl = '{10, 50, -300, 20, 5};
        run_scan("s5_pre", 2, 1200);
        do_start();
        wait_sel(3);
        wait_strobes(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s5_abort_busy", busy, 0);
        repeat (10) tick();
        chk("s5_kept_angle", result_angle, 2);
        chk("s5_kept_energy", result_energy, 1200);
        period = 3;
        run_scan("s5_period3", 2, 1200);
        period = 4;

        do_start();
        wait_sel(2);
        wait_strobes(1);
        reset = 1'b0;
        tick();
        chk("s6_busy", busy, 0);
        chk("s6_angle_sel", angle_sel, 0);
        chk("s6_result_angle", result_angle, 0);
        chk("s6_result_energy", result_energy, 0);
        chk("s6_result_valid", result_valid, 0);
        reset = 1'b1;
        tick();
        run_scan("s6_after", 2, 1200);

        mode = 1;
        for (int r = 0; r < 6; r++) begin
            period = $urandom_range(3, 6);
            do_start();
            if (r == 3) begin
                wait_strobes($urandom_range(1, 25));
                abort = 1'b1;
                tick();
                abort = 1'b0;
                tick();
            end else begin
                wait_valid(600);
                tick();
            end
        end
        period     = $urandom_range(3, 5);
        continuous = 1'b1;
        do_start();
        wait_valid(600);
        wait_valid(600);
        tick();
        continuous = 1'b0;
        wait_valid(600);
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", total);
        $fatal(1);
    end
endmodule
